// File: rtl/dot_product_seq.sv
// Sequential dot product engine.
// Streams captured Pixel/Weight pairs into an external pipelined multiplier,
// accumulates products into FPA_DELAY interleaved partial-sum banks through an
// external pipelined adder, then serially reduces the banks to one value.
module dot_product_seq #(
  parameter int PIXEL_N     = 10,
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int VAL_SIZE    = 26,
  parameter int FPM_DELAY   = 6,
  parameter int FPA_DELAY   = 2
) (
  input  logic                           clk,
  input  logic                           GlobalReset,
  // Control protocol: start is sampled only in IDLE. busy is high from the
  // cycle after acceptance through the DONE cycle; done pulses for exactly
  // one cycle and value is valid from that cycle until the next completion.
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  input  logic [PIXEL_N*PIXEL_SIZE-1:0]  Pixels,
  input  logic [PIXEL_N*WEIGHT_SIZE-1:0] Weights,
  output logic [WEIGHT_SIZE-1:0]         mul_weight,
  output logic [PIXEL_SIZE-1:0]          mul_pixel,
  input  logic [VAL_SIZE-1:0]            mul_result,
  output logic [VAL_SIZE-1:0]            add_a,
  output logic [VAL_SIZE-1:0]            add_b,
  input  logic [VAL_SIZE-1:0]            add_result,
  output logic [VAL_SIZE-1:0]            value,
  output logic [2:0]                     dbg_state_o
);

  localparam int NW = (PIXEL_N > 1) ? $clog2(PIXEL_N) : 1;
  localparam int BW = (FPA_DELAY > 1) ? $clog2(FPA_DELAY) : 1;
  localparam int DW = $clog2(FPM_DELAY + FPA_DELAY + 1);
  // At least two banks so the reduce datapath always has a bank[1] to name;
  // with a single-cycle adder the spare bank is simply never written.
  localparam int NB = (FPA_DELAY > 1) ? FPA_DELAY : 2;

  localparam logic [NW-1:0] LAST_ELEM  = NW'(PIXEL_N - 1);
  localparam logic [BW-1:0] LAST_BANK  = BW'(FPA_DELAY - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(FPM_DELAY + FPA_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FEED   = 3'd1,
    S_DRAIN  = 3'd2,
    S_REDUCE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [NW-1:0] fc_q, fc_d;   // element being fed
  logic [DW-1:0] dc_q, dc_d;   // cycles spent in DRAIN
  logic [BW-1:0] ri_q, ri_d;   // reduce adds issued so far
  logic [BW-1:0] pk_q, pk_d;   // bank for the next product

  logic [PIXEL_SIZE-1:0]  pix_q  [PIXEL_N];
  logic [WEIGHT_SIZE-1:0] wgt_q  [PIXEL_N];
  logic [VAL_SIZE-1:0]    bank_q [NB];
  logic [VAL_SIZE-1:0]    value_q, value_d;

  // Multiplier result-valid pipeline and adder tag pipeline
  // (valid, reduce-add flag, destination bank).
  logic [FPM_DELAY-1:0] mv_q;
  logic [FPA_DELAY-1:0] tv_q;
  logic [FPA_DELAY-1:0] tr_q;
  logic [BW-1:0]        tk_q [FPA_DELAY];

  logic          feed;
  logic          cap;
  logic          prod_v;
  logic          wb_v;
  logic [BW-1:0] wb_k;
  logic          red_ret;
  logic          iss_v;
  logic          iss_r;
  logic [BW-1:0] iss_k;
  logic [BW-1:0] ri_next;

  assign feed    = (state_q == S_FEED);
  assign cap     = (state_q == S_IDLE) && start;
  assign prod_v  = mv_q[FPM_DELAY-1];
  assign wb_v    = tv_q[FPA_DELAY-1] && !tr_q[FPA_DELAY-1];
  assign wb_k    = tk_q[FPA_DELAY-1];
  assign red_ret = tv_q[FPA_DELAY-1] && tr_q[FPA_DELAY-1];
  assign ri_next = ri_q + BW'(1);

  assign busy        = (state_q != S_IDLE);
  assign value       = value_q;
  assign dbg_state_o = state_q;

  // Next-state logic plus multiplier/adder operand steering.
  always_comb begin
    state_d    = state_q;
    fc_d       = fc_q;
    dc_d       = dc_q;
    ri_d       = ri_q;
    pk_d       = pk_q;
    value_d    = value_q;
    done       = 1'b0;
    mul_weight = '0;
    mul_pixel  = '0;
    add_a      = '0;
    add_b      = '0;
    iss_v      = 1'b0;
    iss_r      = 1'b0;
    iss_k      = pk_q;

    // A product arriving from the multiplier is folded into its bank. When
    // that bank's previous sum lands this very cycle, take it straight from
    // the adder output since the bank register still holds the old value.
    if (prod_v) begin
      add_a = mul_result;
      add_b = (wb_v && (wb_k == pk_q)) ? add_result : bank_q[pk_q];
      iss_v = 1'b1;
      iss_k = pk_q;
      pk_d  = (pk_q == LAST_BANK) ? '0 : pk_q + BW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          fc_d    = '0;
          pk_d    = '0;
        end
      end
      S_FEED: begin
        mul_weight = wgt_q[fc_q];
        mul_pixel  = pix_q[fc_q];
        if (fc_q == LAST_ELEM) begin
          state_d = S_DRAIN;
          dc_d    = '0;
        end else begin
          fc_d = fc_q + NW'(1);
        end
      end
      S_DRAIN: begin
        // Ends on the cycle the last product's sum is written back.
        if (dc_q == DRAIN_LAST) begin
          if (FPA_DELAY >= 2) begin
            state_d = S_REDUCE;
            ri_d    = '0;
          end else begin
            state_d = S_DONE;
            value_d = add_result;
          end
        end else begin
          dc_d = dc_q + DW'(1);
        end
      end
      S_REDUCE: begin
        // Serial chain: bank0+bank1, then running total + bank[j], each add
        // launched the cycle the previous total comes back.
        if (ri_q == '0) begin
          add_a = bank_q[0];
          add_b = bank_q[1];
          iss_v = 1'b1;
          iss_r = 1'b1;
          ri_d  = BW'(1);
        end else if (red_ret) begin
          if (ri_q == LAST_BANK) begin
            value_d = add_result;
            state_d = S_DONE;
          end else begin
            add_a = add_result;
            add_b = bank_q[ri_next];
            iss_v = 1'b1;
            iss_r = 1'b1;
            ri_d  = ri_next;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q <= S_IDLE;
      fc_q    <= '0;
      dc_q    <= '0;
      ri_q    <= '0;
      pk_q    <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      dc_q    <= dc_d;
      ri_q    <= ri_d;
      pk_q    <= pk_d;
      value_q <= value_d;
    end
  end

  // Operand capture on acceptance and partial-sum bank writeback.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      for (int i = 0; i < PIXEL_N; i++) begin
        pix_q[i] <= '0;
        wgt_q[i] <= '0;
      end
      for (int j = 0; j < NB; j++) begin
        bank_q[j] <= '0;
      end
    end else if (cap) begin
      for (int i = 0; i < PIXEL_N; i++) begin
        pix_q[i] <= Pixels[i*PIXEL_SIZE +: PIXEL_SIZE];
        wgt_q[i] <= Weights[i*WEIGHT_SIZE +: WEIGHT_SIZE];
      end
      for (int j = 0; j < NB; j++) begin
        bank_q[j] <= '0;
      end
    end else if (wb_v) begin
      bank_q[wb_k] <= add_result;
    end
  end

  // Valid/tag pipelines that mirror the external multiplier and adder latency.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      mv_q <= '0;
      tv_q <= '0;
      tr_q <= '0;
      for (int i = 0; i < FPA_DELAY; i++) begin
        tk_q[i] <= '0;
      end
    end else begin
      mv_q[0] <= feed;
      for (int i = 1; i < FPM_DELAY; i++) begin
        mv_q[i] <= mv_q[i-1];
      end
      tv_q[0] <= iss_v;
      tr_q[0] <= iss_r;
      tk_q[0] <= iss_k;
      for (int i = 1; i < FPA_DELAY; i++) begin
        tv_q[i] <= tv_q[i-1];
        tr_q[i] <= tr_q[i-1];
        tk_q[i] <= tk_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_dot_product_seq.sv
// Bench for dot_product_seq: three instances (adder latency 2, 1, 3) share
// stimulus; each has its own pipelined multiplier/adder model and timing model.
module tb_dot_product_seq;

  localparam int N  = 10;
  localparam int PS = 10;
  localparam int WS = 19;
  localparam int VS = 26;
  localparam int M  = 6;
  localparam int NI = 3;
  localparam int LAT [NI] = '{22, 18, 27};

  // ---------------- clock / reset ----------------
  logic clk;
  logic GlobalReset;
  logic start;
  logic [N*PS-1:0] Pixels;
  logic [N*WS-1:0] Weights;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT wiring ----------------
  logic          busy_w  [NI];
  logic          done_w  [NI];
  logic [WS-1:0] mulw_w  [NI];
  logic [PS-1:0] mulp_w  [NI];
  logic [VS-1:0] mres_w  [NI];
  logic [VS-1:0] adda_w  [NI];
  logic [VS-1:0] addb_w  [NI];
  logic [VS-1:0] ares_w  [NI];
  logic [VS-1:0] value_w [NI];
  logic [2:0]    dbg_w   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int A = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    logic [VS-1:0] mpipe [M];
    logic [VS-1:0] apipe [A];

    dot_product_seq #(
      .PIXEL_N(N), .PIXEL_SIZE(PS), .WEIGHT_SIZE(WS), .VAL_SIZE(VS),
      .FPM_DELAY(M), .FPA_DELAY(A)
    ) u_dut (
      .clk(clk), .GlobalReset(GlobalReset), .start(start),
      .busy(busy_w[g]), .done(done_w[g]),
      .Pixels(Pixels), .Weights(Weights),
      .mul_weight(mulw_w[g]), .mul_pixel(mulp_w[g]), .mul_result(mres_w[g]),
      .add_a(adda_w[g]), .add_b(addb_w[g]), .add_result(ares_w[g]),
      .value(value_w[g]), .dbg_state_o(dbg_w[g])
    );

    // External pipelined multiplier and adder, wrapping at VS bits.
    always_ff @(posedge clk) begin
      mpipe[0] <= VS'(VS'(mulp_w[g]) * VS'(mulw_w[g]));
      for (int i = 1; i < M; i++) mpipe[i] <= mpipe[i-1];
      apipe[0] <= adda_w[g] + addb_w[g];
      for (int i = 1; i < A; i++) apipe[i] <= apipe[i-1];
    end
    assign mres_w[g] = mpipe[M-1];
    assign ares_w[g] = apipe[A-1];
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [VS-1:0] exp_q [NI][$];
  logic [VS-1:0] cur_exp;
  logic [VS-1:0] model_val [NI];
  bit            in_op [NI];
  int            cyc [NI];
  logic [PS-1:0] cap_pix [NI][N];
  logic [WS-1:0] cap_wgt [NI][N];

  typedef struct {
    logic [N*PS-1:0] pix;
    logic [N*WS-1:0] wgt;
    logic [VS-1:0]   exp;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string what, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst=%0d t=%0t got=%0d expected=%0d", what, g, $time, act, exp);
    end
  endtask

  // Reference dot product: exact 64-bit sum truncated to VS bits.
  function automatic logic [VS-1:0] ref_dot(input logic [N*PS-1:0] p, input logic [N*WS-1:0] w);
    longint s;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(p[i*PS +: PS]) * longint'(w[i*WS +: WS]);
    return s[VS-1:0];
  endfunction

  // ---------------- monitor: timing model + output checks ----------------
  initial begin
    for (int g = 0; g < NI; g++) begin
      in_op[g]     = 1'b0;
      cyc[g]       = 0;
      model_val[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        bit exp_done;
        if (in_op[g]) cyc[g]++;
        exp_done = in_op[g] && (cyc[g] == LAT[g]);
        if (exp_done) begin
          if (exp_q[g].size() > 0) model_val[g] = exp_q[g].pop_front();
          else check("queue_empty", g, 64'd1, 64'd0);
        end
        check("busy", g, 64'(busy_w[g]), 64'(in_op[g]));
        check("done", g, 64'(done_w[g]), 64'(exp_done));
        check("value", g, 64'(value_w[g]), 64'(model_val[g]));
        if (in_op[g] && cyc[g] >= 1 && cyc[g] <= N) begin
          check("mul_pixel", g, 64'(mulp_w[g]), 64'(cap_pix[g][cyc[g]-1]));
          check("mul_weight", g, 64'(mulw_w[g]), 64'(cap_wgt[g][cyc[g]-1]));
        end else begin
          check("mul_pixel_idle", g, 64'(mulp_w[g]), 64'd0);
          check("mul_weight_idle", g, 64'(mulw_w[g]), 64'd0);
        end
        if (!in_op[g]) begin
          check("add_a_idle", g, 64'(adda_w[g]), 64'd0);
          check("add_b_idle", g, 64'(addb_w[g]), 64'd0);
          check("state_idle", g, 64'(dbg_w[g]), 64'd0);
        end
        // Advance the model to what the coming edge should do.
        if (GlobalReset) begin
          in_op[g]     = 1'b0;
          cyc[g]       = 0;
          model_val[g] = '0;
          exp_q[g].delete();
        end else if (exp_done) begin
          in_op[g] = 1'b0;
        end else if (!in_op[g] && start) begin
          in_op[g] = 1'b1;
          cyc[g]   = 0;
          for (int i = 0; i < N; i++) begin
            cap_pix[g][i] = Pixels[i*PS +: PS];
            cap_wgt[g][i] = Weights[i*WS +: WS];
          end
          exp_q[g].push_back(cur_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input int budget);
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < budget && !idle; c++) begin
      @(negedge clk);
      #1;
      idle = 1'b1;
      for (int g = 0; g < NI; g++) if (in_op[g] || exp_q[g].size() != 0) idle = 1'b0;
    end
    n_checks++;
    if (!idle) begin
      n_errors++;
      $display("FAIL wait_idle timeout t=%0t", $time);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      Pixels[i*PS +: PS]  = PS'($urandom_range(0, 1023));
      Weights[i*WS +: WS] = WS'($urandom_range(0, 524287));
    end
  endtask

  task automatic run_vec(input int k);
    @(posedge clk); #1;
    Pixels  = tbl[k].pix;
    Weights = tbl[k].wgt;
    cur_exp = tbl[k].exp;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    wait_idle(100);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    GlobalReset = 1'b1;
    start       = 1'b0;
    Pixels      = '0;
    Weights     = '0;
    cur_exp     = '0;

    for (int i = 0; i < N; i++) begin
      tbl[0].pix[i*PS +: PS] = PS'(1);      tbl[0].wgt[i*WS +: WS] = WS'(1);
      tbl[1].pix[i*PS +: PS] = PS'(i + 1);  tbl[1].wgt[i*WS +: WS] = WS'(1);
      tbl[2].pix[i*PS +: PS] = PS'(2);      tbl[2].wgt[i*WS +: WS] = WS'(1);
      tbl[3].pix[i*PS +: PS] = PS'(i + 1);  tbl[3].wgt[i*WS +: WS] = WS'(10 - i);
      tbl[4].pix[i*PS +: PS] = PS'(1023);   tbl[4].wgt[i*WS +: WS] = WS'(524287);
      tbl[5].pix[i*PS +: PS] = PS'($urandom_range(0, 1023));
      tbl[5].wgt[i*WS +: WS] = WS'($urandom_range(0, 524287));
      tbl[6].pix[i*PS +: PS] = PS'($urandom_range(900, 1023));
      tbl[6].wgt[i*WS +: WS] = WS'($urandom_range(400000, 524287));
    end
    tbl[0].exp = VS'(10);
    tbl[1].exp = VS'(55);
    tbl[2].exp = VS'(20);
    tbl[3].exp = VS'(220);
    tbl[4].exp = VS'(61855754);   // 10 * 1023 * 524287 mod 2^26
    tbl[5].exp = ref_dot(tbl[5].pix, tbl[5].wgt);
    tbl[6].exp = ref_dot(tbl[6].pix, tbl[6].wgt);

    repeat (3) @(posedge clk);
    #1 GlobalReset = 1'b0;

    // Table of single operations.
    for (int k = 0; k < 7; k++) run_vec(k);

    // start held high across whole operations: one done each, re-accept on
    // the first IDLE cycle only.
    @(posedge clk); #1;
    Pixels  = tbl[1].pix;
    Weights = tbl[1].wgt;
    cur_exp = tbl[1].exp;
    start   = 1'b1;
    repeat (70) @(posedge clk);
    #1 start = 1'b0;
    wait_idle(100);

    // Reset during FEED cycle 4 aborts; then a fresh operation completes.
    @(posedge clk); #1;
    Pixels  = tbl[3].pix;
    Weights = tbl[3].wgt;
    cur_exp = tbl[3].exp;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 GlobalReset = 1'b1;
    @(posedge clk); #1;
    GlobalReset = 1'b0;
    wait_idle(100);
    repeat (30) @(posedge clk);
    run_vec(4);
    run_vec(0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
